// File: rtl/z80_bus_responder.sv
// Z80 bus-cycle responder: turns CPU strobes into one backing-store request per
// bus cycle, stretches the cycle with wait_n and returns read / vector data.
module z80_bus_responder #(
  parameter int unsigned MIN_WAIT   = 0,
  parameter logic [7:0]  INTACK_VEC = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_di,
  output logic        wait_n,
  output logic        be_req,
  output logic        be_we,
  output logic        be_io,
  output logic [15:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic        be_ack,
  input  logic [7:0]  be_rdata,
  output logic [15:0] fetch_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        wait_q, wait_d;
  logic        we_q, we_d;
  logic        io_q, io_d;
  logic        m1_q, m1_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  di_q, di_d;
  logic [15:0] fcnt_q, fcnt_d;

  logic mem_start, io_start, inta_start, bus_idle;

  // Refresh cycles fail mem_start through rfsh_n and are never serviced.
  assign mem_start  = !mreq_n && rfsh_n && (!rd_n || !wr_n);
  assign io_start   = !iorq_n && m1_n && (!rd_n || !wr_n);
  assign inta_start = !iorq_n && !m1_n;
  assign bus_idle   = mreq_n && iorq_n && rd_n && wr_n;

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != 4'hF) ? cnt_q + 4'd1 : cnt_q;
    req_d   = req_q;
    wait_d  = wait_q;
    we_d    = we_q;
    io_d    = io_q;
    m1_d    = m1_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    di_d    = di_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      S_IDLE: begin
        if (mem_start) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          wait_d  = 1'b0;
          we_d    = !wr_n;
          io_d    = 1'b0;
          m1_d    = !m1_n;
          addr_d  = A;
          wdata_d = cpu_dout;
          cnt_d   = 4'd1;
        end else if (io_start) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          wait_d  = 1'b0;
          we_d    = !wr_n;
          io_d    = 1'b1;
          m1_d    = 1'b0;
          addr_d  = {8'h00, A[7:0]};
          wdata_d = cpu_dout;
          cnt_d   = 4'd1;
        end else if (inta_start) begin
          state_d = S_WAIT;
          wait_d  = 1'b0;
          di_d    = INTACK_VEC;
          cnt_d   = 4'd1;
        end
      end
      S_REQ: begin
        if (be_ack) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
          if (!we_q) di_d = be_rdata;
          if (!we_q && !io_q && m1_q) fcnt_d = fcnt_q + 16'd1;
        end
      end
      S_WAIT: begin
        // cnt_q holds the number of edges elapsed since the start edge.
        if (cnt_q >= 4'(MIN_WAIT)) begin
          state_d = S_HOLD;
          wait_d  = 1'b1;
        end
      end
      default: begin
        if (bus_idle) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      req_q   <= 1'b0;
      wait_q  <= 1'b1;
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      m1_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      di_q    <= 8'h00;
      fcnt_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      wait_q  <= wait_d;
      we_q    <= we_d;
      io_q    <= io_d;
      m1_q    <= m1_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      di_q    <= di_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign cpu_di    = di_q;
  assign wait_n    = wait_q;
  assign be_req    = req_q;
  assign be_we     = we_q;
  assign be_io     = io_q;
  assign be_addr   = addr_q;
  assign be_wdata  = wdata_q;
  assign fetch_cnt = fcnt_q;

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: one instance with MIN_WAIT=0 and one
// with MIN_WAIT=2 share the same CPU and backing-store stimulus.
module tb_z80_bus_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        m1_n, mreq_n, iorq_n, rd_n, wr_n, rfsh_n;
  logic [15:0] A;
  logic [7:0]  cpu_dout;
  logic        be_ack;
  logic [7:0]  be_rdata;

  logic [7:0]  cpu_di0, cpu_di2;
  logic        wait_n0, wait_n2;
  logic        be_req0, be_req2, be_we0, be_we2, be_io0, be_io2;
  logic [15:0] be_addr0, be_addr2, fetch_cnt0, fetch_cnt2;
  logic [7:0]  be_wdata0, be_wdata2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  z80_bus_responder #(.MIN_WAIT(0), .INTACK_VEC(8'hFF)) dut0 (
    .clk(clk), .reset(reset), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .A(A), .cpu_dout(cpu_dout),
    .cpu_di(cpu_di0), .wait_n(wait_n0), .be_req(be_req0), .be_we(be_we0),
    .be_io(be_io0), .be_addr(be_addr0), .be_wdata(be_wdata0),
    .be_ack(be_ack), .be_rdata(be_rdata), .fetch_cnt(fetch_cnt0)
  );

  z80_bus_responder #(.MIN_WAIT(2), .INTACK_VEC(8'hFF)) dut2 (
    .clk(clk), .reset(reset), .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n),
    .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n), .A(A), .cpu_dout(cpu_dout),
    .cpu_di(cpu_di2), .wait_n(wait_n2), .be_req(be_req2), .be_we(be_we2),
    .be_io(be_io2), .be_addr(be_addr2), .be_wdata(be_wdata2),
    .be_ack(be_ack), .be_rdata(be_rdata), .fetch_cnt(fetch_cnt2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_release();
    m1_n = 1'b1; mreq_n = 1'b1; iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++; if (be_req0 !== 1'b0) begin n_err++; $display("FAIL rst_req: got %b exp 0", be_req0); end
    n_cmp++; if (wait_n0 !== 1'b1) begin n_err++; $display("FAIL rst_wait: got %b exp 1", wait_n0); end
    n_cmp++; if ({be_we0, be_io0} !== 2'b00) begin n_err++; $display("FAIL rst_flags: got %b exp 00", {be_we0, be_io0}); end
    n_cmp++; if ({be_addr0, be_wdata0, cpu_di0} !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h exp 0", {be_addr0, be_wdata0, cpu_di0}); end
    n_cmp++; if (fetch_cnt0 !== 16'h0) begin n_err++; $display("FAIL rst_fcnt: got %h exp 0000", fetch_cnt0); end
  endtask

  task automatic test_m1_fetch();
    A = 16'h0000; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    n_cmp++; if ({be_req0, wait_n0, be_we0, be_io0} !== 4'b1000) begin n_err++; $display("FAIL fetch_start: got %b exp 1000", {be_req0, wait_n0, be_we0, be_io0}); end
    n_cmp++; if (be_addr0 !== 16'h0000) begin n_err++; $display("FAIL fetch_addr: got %h exp 0000", be_addr0); end
    be_ack = 1'b1; be_rdata = 8'hCB;
    tick();
    be_ack = 1'b0;
    n_cmp++; if ({be_req0, wait_n0} !== 2'b00) begin n_err++; $display("FAIL fetch_ack: got %b exp 00", {be_req0, wait_n0}); end
    n_cmp++; if (cpu_di0 !== 8'hCB) begin n_err++; $display("FAIL fetch_di: got %h exp CB", cpu_di0); end
    n_cmp++; if (fetch_cnt0 !== 16'h0001) begin n_err++; $display("FAIL fetch_cnt: got %h exp 0001", fetch_cnt0); end
    tick();
    n_cmp++; if (wait_n0 !== 1'b1) begin n_err++; $display("FAIL fetch_wait_rel: got %b exp 1", wait_n0); end
    n_cmp++; if (wait_n2 !== 1'b1) begin n_err++; $display("FAIL fetch_wait_rel2: got %b exp 1", wait_n2); end
    bus_release();
    tick(); tick();
    n_cmp++; if (be_req0 !== 1'b0) begin n_err++; $display("FAIL fetch_single: got %b exp 0", be_req0); end
  endtask

  task automatic test_mem_write();
    A = 16'hF913; cpu_dout = 8'hCF; mreq_n = 1'b0; wr_n = 1'b0;
    tick();
    A = 16'h1234; cpu_dout = 8'h00;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({be_req0, be_we0, be_io0, wait_n0} !== 4'b1100) begin n_err++; $display("FAIL wr_ctrl%0d: got %b exp 1100", i, {be_req0, be_we0, be_io0, wait_n0}); end
      n_cmp++; if ({be_addr0, be_wdata0} !== 24'hF913CF) begin n_err++; $display("FAIL wr_data%0d: got %h exp F913CF", i, {be_addr0, be_wdata0}); end
      if (i == 2) be_ack = 1'b1;
      tick();
    end
    be_ack = 1'b0;
    n_cmp++; if ({be_req0, wait_n0} !== 2'b00) begin n_err++; $display("FAIL wr_ack: got %b exp 00", {be_req0, wait_n0}); end
    tick();
    n_cmp++; if (wait_n0 !== 1'b1) begin n_err++; $display("FAIL wr_wait_rel: got %b exp 1", wait_n0); end
    n_cmp++; if ({fetch_cnt0, cpu_di0} !== 24'h0001CB) begin n_err++; $display("FAIL wr_nochange: got %h exp 0001CB", {fetch_cnt0, cpu_di0}); end
    bus_release();
    tick(); tick();
  endtask

  task automatic test_refresh();
    A = 16'h0002; mreq_n = 1'b0; rfsh_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({be_req0, wait_n0, be_req2, wait_n2} !== 4'b0101) begin n_err++; $display("FAIL rfsh%0d: got %b exp 0101", i, {be_req0, wait_n0, be_req2, wait_n2}); end
    end
    bus_release();
    tick();
  endtask

  task automatic test_intack();
    iorq_n = 1'b0; m1_n = 1'b0;
    tick();
    n_cmp++; if ({be_req2, wait_n2, cpu_di2} !== 10'b00_1111_1111) begin n_err++; $display("FAIL inta_start: got %b exp 0011111111", {be_req2, wait_n2, cpu_di2}); end
    tick();
    n_cmp++; if (wait_n2 !== 1'b0) begin n_err++; $display("FAIL inta_wait1: got %b exp 0", wait_n2); end
    n_cmp++; if (wait_n0 !== 1'b1) begin n_err++; $display("FAIL inta_wait0: got %b exp 1", wait_n0); end
    tick();
    n_cmp++; if ({wait_n2, be_req2} !== 2'b10) begin n_err++; $display("FAIL inta_rel: got %b exp 10", {wait_n2, be_req2}); end
    bus_release();
    tick(); tick();
  endtask

  task automatic test_io_read();
    A = 16'h12FE; iorq_n = 1'b0; rd_n = 1'b0;
    tick();
    n_cmp++; if ({be_req0, be_io0, be_we0, be_addr0} !== {3'b110, 16'h00FE}) begin n_err++; $display("FAIL io_req: got %b/%h exp 110/00FE", {be_req0, be_io0, be_we0}, be_addr0); end
    be_ack = 1'b1; be_rdata = 8'h5A;
    tick();
    be_ack = 1'b0;
    n_cmp++; if ({cpu_di0, fetch_cnt0} !== 24'h5A0001) begin n_err++; $display("FAIL io_read: got %h exp 5A0001", {cpu_di0, fetch_cnt0}); end
    bus_release();
    tick(); tick();
    be_ack = 1'b1; be_rdata = 8'h77;
    tick();
    be_ack = 1'b0;
    n_cmp++; if ({be_req0, cpu_di0} !== 9'h05A) begin n_err++; $display("FAIL stray_ack: got %h exp 05A", {be_req0, cpu_di0}); end
  endtask

  task automatic test_priority();
    A = 16'hABCD; mreq_n = 1'b0; iorq_n = 1'b0; rd_n = 1'b0;
    tick();
    n_cmp++; if ({be_req0, be_io0, be_addr0} !== {2'b10, 16'hABCD}) begin n_err++; $display("FAIL prio: got %b/%h exp 10/ABCD", {be_req0, be_io0}, be_addr0); end
    be_ack = 1'b1; be_rdata = 8'h11;
    tick();
    be_ack = 1'b0;
    n_cmp++; if ({cpu_di0, fetch_cnt0} !== 24'h110001) begin n_err++; $display("FAIL prio_done: got %h exp 110001", {cpu_di0, fetch_cnt0}); end
    bus_release();
    tick(); tick();
  endtask

  task automatic test_strobe_early();
    A = 16'h0100; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    bus_release();
    tick();
    n_cmp++; if (be_req0 !== 1'b1) begin n_err++; $display("FAIL early_hold: got %b exp 1", be_req0); end
    be_ack = 1'b1; be_rdata = 8'h3C;
    tick();
    be_ack = 1'b0;
    n_cmp++; if ({be_req0, cpu_di0} !== 9'h03C) begin n_err++; $display("FAIL early_done: got %h exp 03C", {be_req0, cpu_di0}); end
    tick();
    n_cmp++; if (wait_n0 !== 1'b1) begin n_err++; $display("FAIL early_wait: got %b exp 1", wait_n0); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if ({be_req0, be_req2} !== 2'b00) begin n_err++; $display("FAIL early_second%0d: got %b exp 00", i, {be_req0, be_req2}); end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) begin
      A = 16'(16'h0010 + i); m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
      tick();
      n_cmp++; if ({be_req0, be_addr0} !== {1'b1, 16'(16'h0010 + i)}) begin n_err++; $display("FAIL b2b_req%0d: got %b/%h exp 1/%h", i, be_req0, be_addr0, 16'(16'h0010 + i)); end
      be_ack = 1'b1; be_rdata = 8'(8'hA0 + i);
      tick();
      be_ack = 1'b0;
      tick();
      bus_release();
      tick();
    end
    n_cmp++; if ({fetch_cnt0, cpu_di0} !== 24'h0003A1) begin n_err++; $display("FAIL b2b_cnt: got %h exp 0003A1", {fetch_cnt0, cpu_di0}); end
  endtask

  task automatic test_reset_mid();
    A = 16'h4444; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0;
    tick();
    n_cmp++; if (be_req0 !== 1'b1) begin n_err++; $display("FAIL rmid_req: got %b exp 1", be_req0); end
    reset = 1'b1;
    #1;
    n_cmp++; if ({be_req0, wait_n0, be_we0, be_io0} !== 4'b0100) begin n_err++; $display("FAIL rmid_async: got %b exp 0100", {be_req0, wait_n0, be_we0, be_io0}); end
    n_cmp++; if ({be_addr0, cpu_di0, fetch_cnt0} !== 40'h0) begin n_err++; $display("FAIL rmid_data: got %h exp 0", {be_addr0, cpu_di0, fetch_cnt0}); end
    bus_release();
    tick();
    reset = 1'b0;
    be_ack = 1'b1; be_rdata = 8'h99;
    tick();
    be_ack = 1'b0;
    n_cmp++; if ({be_req0, wait_n0, cpu_di0, fetch_cnt0} !== {2'b01, 8'h00, 16'h0000}) begin n_err++; $display("FAIL rmid_late_ack: got %b/%h/%h exp 01/00/0000", {be_req0, wait_n0}, cpu_di0, fetch_cnt0); end
    tick();
    n_cmp++; if ({be_req2, wait_n2, cpu_di2} !== {2'b01, 8'h00}) begin n_err++; $display("FAIL rmid_idle2: got %b/%h exp 01/00", {be_req2, wait_n2}, cpu_di2); end
  endtask

  initial begin
    reset = 1'b1; bus_release();
    A = 16'h0; cpu_dout = 8'h0; be_ack = 1'b0; be_rdata = 8'h0;
    #2;
    test_reset();
    tick();
    reset = 1'b0;
    tick();
    test_m1_fetch();
    test_mem_write();
    test_refresh();
    test_intack();
    test_io_read();
    test_priority();
    test_strobe_early();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
